// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access controller.
//   spi_state_e : controller FSM states
//   MODE_CPOL   : bit position of CPOL inside the 2-bit mode field
//   MODE_CPHA   : bit position of CPHA inside the 2-bit mode field
//   frame_len() : frame length in bits (rw flag + address + data)
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    function automatic int frame_len(input int addr_w, input int reg_w);
        return 1 + addr_w + reg_w;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator. While en is high it toggles sclk every CLK_DIV clk cycles
// and flags which toggle is the leading (first) and trailing (second) edge of
// each SCLK period. While en is low the divider is cleared and sclk parks at
// cpol, so every enable starts a fresh, phase-aligned SCLK period.
//   clk, rstb : system clock, async active-low reset
//   en        : run the divider
//   cpol      : idle level of sclk
//   sclk      : registered SPI clock level
//   lead      : high in the cycle whose closing clk edge makes a leading edge
//   trail     : high in the cycle whose closing clk edge makes a trailing edge
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic cpol,
    output logic sclk,
    output logic lead,
    output logic trail
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             phase_r;
    logic             sclk_r;
    logic             wrap_s;

    // Edge strobes: the half-period expires on the last divider count
    always_comb begin
        wrap_s = (div_cnt_r == DIV_END);
        lead   = en & wrap_s & ~phase_r;
        trail  = en & wrap_s & phase_r;
    end

    // Divider counter, half-period phase and SCLK level
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt_r <= {DIV_W{1'b0}};
            phase_r   <= 1'b0;
            sclk_r    <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= {DIV_W{1'b0}};
            phase_r   <= 1'b0;
            sclk_r    <= cpol;
        end else if (wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            phase_r   <= ~phase_r;
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_controller.sv
// SPI master for single-register read/write frames.
// A frame is {wr_rdn, addr, data} shifted MSB first; data is wdata on a
// write and zeros on a read, and the last REG_W bits sampled from MISO of a
// read frame become rdata. Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP.
//   clk, rstb      : system clock, async active-low reset
//   ena            : block enable; dropping it mid-frame aborts the frame
//   mode           : {CPOL, CPHA}
//   start          : one-cycle request, taken only when idle and enabled
//   wr_rdn         : 1 = write, 0 = read
//   addr, wdata    : register address and write data
//   rdata          : data of the last completed read
//   busy           : frame or inter-frame gap in progress
//   done           : one-cycle pulse as chip-select rises after a full frame
//   spi_cs_n       : chip select, active low
//   spi_clk        : SPI clock
//   spi_mosi       : SPI data out (0 whenever chip select is inactive)
//   spi_miso       : SPI data in
module spi_controller
    import spi_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              wr_rdn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic [REG_W-1:0]  rdata,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int FRAME_LEN = frame_len(ADDR_W, REG_W);
    localparam int BIT_W     = $clog2(FRAME_LEN);
    localparam int TMR_W     = $clog2(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    spi_state_e state_r;
    spi_state_e state_s;

    logic [TMR_W-1:0]     tmr_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [FRAME_LEN-1:0] sh_r;
    logic [REG_W-1:0]     rx_r;
    logic [REG_W-1:0]     rdata_r;
    logic [1:0]           mode_r;
    logic                 wr_r;
    logic                 cs_n_r;
    logic                 mosi_r;
    logic                 busy_r;
    logic                 done_r;

    logic [FRAME_LEN-1:0] frame_s;
    logic                 accept_s;
    logic                 finish_s;
    logic                 active_s;
    logic                 tmr_end_s;
    logic                 cpol_s;
    logic                 cpha_s;
    logic                 gen_en_s;
    logic                 sclk_s;
    logic                 lead_s;
    logic                 trail_s;
    logic                 shift_s;
    logic                 sample_s;

    // SCLK generator control: idle level follows the live mode until a frame
    // latches it; dropping ena stops SCLK in the same edge it is seen
    always_comb begin
        if (state_r == ST_IDLE) begin
            cpol_s = mode[MODE_CPOL];
        end else begin
            cpol_s = mode_r[MODE_CPOL];
        end
        gen_en_s = (state_r == ST_SHIFT) && ena;
    end

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rstb  (rstb),
        .en    (gen_en_s),
        .cpol  (cpol_s),
        .sclk  (sclk_s),
        .lead  (lead_s),
        .trail (trail_s)
    );

    // Datapath decode: which SCLK edge shifts MOSI and which samples MISO
    always_comb begin
        cpha_s    = mode_r[MODE_CPHA];
        tmr_end_s = (tmr_r == TMR_END);
        frame_s   = {wr_rdn, addr, (wr_rdn ? wdata : {REG_W{1'b0}})};
        if (cpha_s) begin
            shift_s  = lead_s;
            sample_s = trail_s;
        end else begin
            shift_s  = trail_s;
            sample_s = lead_s;
        end
    end

    // FSM next state and single-cycle control strobes
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && ena) begin
                    state_s  = ST_SETUP;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!ena) begin
                    state_s = ST_GAP;
                end else if (tmr_end_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                // The trailing edge of the last bit closes the frame
                if (!ena) begin
                    state_s = ST_GAP;
                end else if (trail_s && (bit_cnt_r == BIT_ZERO)) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (!ena) begin
                    state_s = ST_GAP;
                end else if (tmr_end_s) begin
                    state_s  = ST_GAP;
                    finish_s = 1'b1;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (tmr_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        active_s = (state_s == ST_SETUP) || (state_s == ST_SHIFT) ||
                   (state_s == ST_HOLD);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Per-state cycle timer, cleared whenever the state changes
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tmr_r <= TMR_ZERO;
        end else if (state_s != state_r) begin
            tmr_r <= TMR_ZERO;
        end else if ((state_r == ST_SETUP) || (state_r == ST_HOLD) ||
                     (state_r == ST_GAP)) begin
            tmr_r <= tmr_r + TMR_W'(1'b1);
        end else begin
            tmr_r <= TMR_ZERO;
        end
    end

    // Frame latch, transmit shift register and bit counter. With CPHA=0 the
    // first bit goes straight to MOSI at acceptance, so the register is
    // preloaded one position ahead.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sh_r      <= {FRAME_LEN{1'b0}};
            bit_cnt_r <= BIT_ZERO;
            wr_r      <= 1'b0;
            mode_r    <= 2'b00;
        end else if (accept_s) begin
            sh_r      <= mode[MODE_CPHA] ? frame_s
                                         : {frame_s[FRAME_LEN-2:0], 1'b0};
            bit_cnt_r <= BIT_LAST;
            wr_r      <= wr_rdn;
            mode_r    <= mode;
        end else if (state_r == ST_SHIFT) begin
            if (shift_s) begin
                sh_r <= {sh_r[FRAME_LEN-2:0], 1'b0};
            end
            if (trail_s && (bit_cnt_r != BIT_ZERO)) begin
                bit_cnt_r <= bit_cnt_r - BIT_W'(1'b1);
            end
        end
    end

    // Chip select and MOSI; MOSI is forced low whenever CS is inactive
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_n_r <= 1'b1;
            mosi_r <= 1'b0;
        end else begin
            cs_n_r <= ~active_s;
            if (!active_s) begin
                mosi_r <= 1'b0;
            end else if (accept_s) begin
                mosi_r <= mode[MODE_CPHA] ? 1'b0 : frame_s[FRAME_LEN-1];
            end else if ((state_r == ST_SHIFT) && shift_s) begin
                mosi_r <= sh_r[FRAME_LEN-1];
            end
        end
    end

    // MISO capture; only the last REG_W samples of the frame are kept
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_r <= {REG_W{1'b0}};
        end else if (accept_s) begin
            rx_r <= {REG_W{1'b0}};
        end else if ((state_r == ST_SHIFT) && sample_s) begin
            rx_r <= {rx_r[REG_W-2:0], spi_miso};
        end
    end

    // Status outputs: rdata only updates on a read that ran to completion
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rdata_r <= {REG_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= finish_s;
            if (finish_s && !wr_r) begin
                rdata_r <= rx_r;
            end
        end
    end

    assign rdata    = rdata_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign spi_cs_n = cs_n_r;
    assign spi_clk  = sclk_s;
    assign spi_mosi = mosi_r;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller (ADDR_W=4, REG_W=8, CLK_DIV=2).
// The driver pushes the expected MOSI frame, rdata and acceptance time for
// every request it expects to complete; the monitor pops an entry on every
// done pulse. A behavioural SPI slave serves MISO and records MOSI on the
// slave's sampling edges.
module tb_spi_controller;

    localparam int ADDR_W  = 4;
    localparam int REG_W   = 8;
    localparam int CLK_DIV = 2;
    localparam int FL      = 1 + ADDR_W + REG_W;
    localparam int LAT     = (2 + 2 * FL) * CLK_DIV;
    localparam int PERIOD  = 10;

    logic              clk;
    logic              rstb;
    logic              ena;
    logic [1:0]        mode;
    logic              start;
    logic              wr_rdn;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic [REG_W-1:0]  rdata;
    logic              busy;
    logic              done;
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    spi_controller #(
        .ADDR_W  (ADDR_W),
        .REG_W   (REG_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .mode     (mode),
        .start    (start),
        .wr_rdn   (wr_rdn),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [FL-1:0]    mosi;
        logic [REG_W-1:0] rdata;
        longint           t_acc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks  = 0;
    int n_pass    = 0;
    int done_cnt  = 0;
    int mosi_viol = 0;
    logic [REG_W-1:0] model_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Behavioural slave: shifts its response out, records MOSI on sampling edges
    logic [1:0]    cur_mode   = 2'b00;
    logic [FL-1:0] slave_resp = '0;
    logic [FL-1:0] cap_bits   = '0;
    int            cap_cnt    = 0;
    int            lead_cnt   = 0;
    int            sidx       = 0;
    logic          prev_cs    = 1'b1;
    logic          prev_sclk  = 1'b0;

    always @(spi_cs_n or spi_clk) begin
        logic leading;
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            cap_cnt  = 0;
            lead_cnt = 0;
            cap_bits = '0;
            if (!cur_mode[0]) begin
                spi_miso = slave_resp[FL-1];
                sidx     = FL - 2;
            end else begin
                sidx = FL - 1;
            end
        end else if (spi_cs_n === 1'b0 && spi_clk !== prev_sclk) begin
            leading = (spi_clk != cur_mode[1]);
            if (leading) lead_cnt++;
            if (leading ^ cur_mode[0]) begin
                cap_bits = {cap_bits[FL-2:0], spi_mosi};
                cap_cnt++;
            end else if (sidx >= 0) begin
                spi_miso = slave_resp[sidx];
                sidx--;
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_clk;
    end

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        exp_t e;
        if (rstb === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
                e = exp_q.pop_front();
                check("latency", 32'(($time - e.t_acc) / PERIOD), 32'(LAT));
                check("rdata", 32'(rdata), 32'(e.rdata));
                check("cs_n_at_done", 32'(spi_cs_n), 32'd1);
                check("mosi_bit_count", 32'(cap_cnt), 32'(FL));
                check("mosi_frame", 32'(cap_bits), 32'(e.mosi));
            end
        end
        if (rstb === 1'b1 && spi_cs_n === 1'b1 && spi_mosi !== 1'b0) begin
            mosi_viol++;
        end
    end

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [REG_W-1:0] d, input logic [REG_W-1:0] sd,
                         input bit push);
        exp_t e;
        @(negedge clk);
        wr_rdn     = wr;
        addr       = a;
        wdata      = d;
        slave_resp = {{(FL - REG_W){1'b0}}, sd};
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) begin
            if (!wr) model_rdata = sd;
            e.mosi  = {wr, a, (wr ? d : 8'h00)};
            e.rdata = model_rdata;
            e.t_acc = longint'($time);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_mode(input logic [1:0] m, input string name);
        @(negedge clk);
        mode     = m;
        cur_mode = m;
        repeat (2) @(negedge clk);
        check(name, 32'(spi_clk), 32'(m[1]));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_leads(input int n, input string name);
        int k = 0;
        while (lead_cnt < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(lead_cnt >= n), 32'd1);
    endtask

    initial begin
        int dc;
        rstb   = 1'b0;
        ena    = 1'b0;
        mode   = 2'b00;
        start  = 1'b0;
        wr_rdn = 1'b0;
        addr   = '0;
        wdata  = '0;
        #(PERIOD * 2 + 2);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sclk", 32'(spi_clk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        ena  = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 write 0x3 <- 0xA5
        set_mode(2'b00, "idle_sclk_m0");
        issue(1'b1, 4'h3, 8'hA5, 8'h00, 1'b1);
        wait_idle("idle_after_m0_write");

        // Mode 3 read 0xA, slave returns 0x5C
        set_mode(2'b11, "idle_sclk_m3");
        issue(1'b0, 4'hA, 8'h00, 8'h5C, 1'b1);
        wait_idle("idle_after_m3_read");

        // Abort by dropping ena in SCLK period 5
        dc = done_cnt;
        issue(1'b0, 4'h6, 8'h00, 8'h77, 1'b0);
        wait_leads(5, "abort_reach_period5");
        ena = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sclk_cpol", 32'(spi_clk), 32'd1);
        check("abort_mosi", 32'(spi_mosi), 32'd0);
        wait_idle("idle_after_abort");
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_rdata_kept", 32'(rdata), 32'h5C);
        ena = 1'b1;
        issue(1'b1, 4'h1, 8'h12, 8'h00, 1'b1);
        wait_idle("idle_after_post_abort_write");

        // Mode 1 read with a second start pulsed mid-frame
        set_mode(2'b01, "idle_sclk_m1");
        dc = done_cnt;
        issue(1'b0, 4'hA, 8'h00, 8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        wr_rdn = 1'b1;
        addr   = 4'hF;
        wdata  = 8'hFF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("idle_after_m1_read");
        check("one_done_per_accept", 32'(done_cnt), 32'(dc + 1));

        // Mode 2 read
        set_mode(2'b10, "idle_sclk_m2");
        issue(1'b0, 4'hA, 8'h00, 8'h3C, 1'b1);
        wait_idle("idle_after_m2_read");

        // start with ena low is ignored
        ena = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("ena0_busy", 32'(busy), 32'd0);
        check("ena0_cs_n", 32'(spi_cs_n), 32'd1);
        ena = 1'b1;

        // Reset mid-SHIFT, then a write of 0xFF in mode 2
        set_mode(2'b00, "idle_sclk_m0_again");
        issue(1'b1, 4'h7, 8'h11, 8'h00, 1'b0);
        wait_leads(3, "reset_reach_shift");
        rstb = 1'b0;
        #1;
        check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        check("midrst_sclk", 32'(spi_clk), 32'd0);
        check("midrst_mosi", 32'(spi_mosi), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        model_rdata = 8'h00;
        mode        = 2'b10;
        cur_mode    = 2'b10;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("sclk_cpol_after_reset", 32'(spi_clk), 32'd1);
        issue(1'b1, 4'h5, 8'hFF, 8'h00, 1'b1);
        wait_idle("idle_after_post_reset_write");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("mosi_low_when_cs_high", 32'(mosi_viol), 32'd0);
        check("total_done_count", 32'(done_cnt), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
